// File: rtl/systolic_result_drain.sv
// Collects one result per PE of an N x N systolic array, then drains them in slot order
// over a valid/ready stream. Optional sticky overrun flag under `DRAIN_OVERRUN_ERR_EN.
module systolic_result_drain #(
  parameter int N  = 4,
  parameter int DW = 16,
  localparam int S  = N * N,
  localparam int IW = (S > 1) ? $clog2(S) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [S*DW-1:0] pe_result,
  input  logic [S-1:0]    pe_valid,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done
`ifdef DRAIN_OVERRUN_ERR_EN
  ,
  output logic            err_overrun
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [S-1:0]    mask_q, mask_d, cap;
  logic [DW-1:0]   buf_q [S];
  logic [DW-1:0]   buf_d [S];
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d, last_q, last_d;
  logic            busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cap     = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = COLLECT;
        mask_d  = '0;
      end
      COLLECT: begin
        // Only first assertion of a slot is captured; PEs keep result_valid high.
        cap = pe_valid & ~mask_q;
        for (int k = 0; k < S; k++)
          if (cap[k]) buf_d[k] = pe_result[k*DW +: DW];
        mask_d = mask_q | cap;
        if (&mask_d) begin
          state_d = DRAIN;
          idx_d   = '0;
          data_d  = buf_d[0];
        end
      end
      DRAIN: if (out_ready) begin
        if (idx_q == IW'(S-1)) begin
          state_d = DONE;
          idx_d   = '0;
          data_d  = '0;
        end else begin
          idx_d  = idx_q + 1'b1;
          data_d = buf_q[idx_d];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DRAIN);
    last_d  = valid_d && (idx_d == IW'(S-1));
    busy_d  = (state_d == COLLECT) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      for (int k = 0; k < S; k++) buf_q[k] <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_data  = data_q;
  assign out_index = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef DRAIN_OVERRUN_ERR_EN
  logic         err_q, err_d;
  logic [S-1:0] pv_prev_q;

  // A rising valid on a captured slot means a PE produced a second result mid-collection.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start)
      err_d = 1'b0;
    else if ((start && (state_q == COLLECT || state_q == DRAIN)) ||
             (state_q == COLLECT && |(pe_valid & ~pv_prev_q & mask_q)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      pv_prev_q <= '0;
    end else begin
      err_q     <= err_d;
      pv_prev_q <= pe_valid;
    end
  end

  assign err_overrun = err_q;
`endif

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter N, default 4, meaning systolic array dimension (N x N PEs).
REQ-002 SHALL have parameter DW, default 16, meaning width of one PE result.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin a new collection; one-cycle pulse.
REQ-006 SHALL have port pe_result  input  N*N*DW  flattened PE results; slot k = ROW*N+COL occupies bits [k*DW +: DW].
REQ-007 SHALL have port pe_valid  input  N*N  per-PE result_valid; bit k belongs to slot k.
REQ-008 SHALL have port out_data  output  DW  result being drained.
REQ-009 SHALL have port out_index  output  log2(N*N)  slot number of out_data.
REQ-010 SHALL have port out_valid  output  1  out_data/out_index valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the current word.
REQ-012 SHALL have port out_last  output  1  high with out_valid on slot N*N-1.
REQ-013 SHALL have port busy  output  1  high in COLLECT or DRAIN.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final handshake.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DRAIN, DONE.
REQ-016 IDLE: start=1 -> COLLECT next edge; capture mask cleared on the same edge.
REQ-017 COLLECT: on each edge, every slot k with pe_valid[k]=1 and mask[k]=0 SHALL latch pe_result slot k into buffer k and set mask[k].
REQ-018 A slot already captured SHALL keep its first value; later pe_valid or pe_result changes are ignored (PEs hold result_valid high).
REQ-019 When (mask | newly captured) becomes all-ones on an edge, state SHALL go to DRAIN on that same edge; out_valid high in the following cycle with out_index=0.
REQ-020 DRAIN: out_valid=1; out_data=buffer[out_index]; index advances by 1 only on out_valid&&out_ready.
REQ-021 While out_ready=0, out_data, out_index, out_last SHALL remain stable.
REQ-022 Handshake on index N*N-1 -> DONE; out_valid=0 in DONE.
REQ-023 DONE lasts exactly one cycle with done=1, then IDLE.
REQ-024 pe_valid in IDLE or DONE SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-025 out_data SHALL be the captured DW-bit value unmodified; no arithmetic.
REQ-026 Drain throughput SHALL be one word per cycle when out_ready held high; N*N words in N*N cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, mask=0, out_index=0, out_valid=0, out_last=0, busy=0, done=0, out_data=0, buffers=0.
REQ-028 Reset mid-COLLECT or mid-DRAIN SHALL abandon the operation; no done pulse; next start begins clean.

Configuration
REQ-029 Macro DRAIN_OVERRUN_ERR_EN: when defined, port err_overrun output 1 SHALL exist, set sticky by start while busy or by pe_valid[k] rising (0->1) on an already-captured slot in COLLECT; cleared only by reset or start accepted in IDLE.
REQ-030 When DRAIN_OVERRUN_ERR_EN is undefined, port err_overrun and its logic SHALL be absent; those events are silently ignored.

Verification
REQ-031 Reset, start, all 16 pe_valid high together with slot k value = k+1, out_ready=1 -> out_valid one cycle after capture edge; out_data 1..16 on consecutive cycles, out_last on 16th, done next cycle.
REQ-032 Skewed valids: slot ROW*4+COL asserted at cycle ROW+COL+5 after start, held high with changing pe_result -> drained values equal values at first-valid cycle.
REQ-033 out_ready toggled 1,0,0,1 repeatedly during drain -> no word lost or duplicated, outputs stable during stalls, 16 handshakes total.
REQ-034 rst_n pulsed low after 7 handshakes -> out_valid=0 immediately, no done; subsequent start with values 100..115 drains 100..115.
REQ-035 start during DRAIN, and pe_valid high in IDLE -> ignored; with DRAIN_OVERRUN_ERR_EN, err_overrun=1 until next accepted start.
